// File: rtl/scratchpad_port_arbiter.sv
// Round-robin burst arbiter in front of the single-port scratchpad SRAM.
// Three requesters (loader write, PE operand read, writeback write) share it.
module scratchpad_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_i,
  input  logic [3*ADDR_W-1:0] addr_i,
  input  logic [3*LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0]   ld_wdata_i,
  input  logic [DATA_W-1:0]   fm_wdata_i,
  input  logic                abort_i,
  output logic [2:0]          gnt_o,
  output logic [2:0]          beat_o,
  output logic [DATA_W-1:0]   cp_rdata_o,
  output logic                cp_rvld_o,
  output logic                sram_cs_o,
  output logic                sram_we_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  input  logic [DATA_W-1:0]   sram_rdata_i,
  output logic                busy_o,
  output logic                dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [LEN_W-1:0]    beats_left_q, beats_left_d;
  logic [1:0]          rr_last_q, rr_last_d;
  logic                first_q, first_d;
  logic                rvld_q, rvld_d;

  logic [1:0]          cand0, cand1, winner;
  logic [ADDR_W-1:0]   win_addr;
  logic [LEN_W-1:0]    win_len;
  logic [2:0]          owner_oh;
  logic                in_burst;

  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search order rr_last+1, rr_last+2, rr_last: a just-served requester goes last.
  always_comb begin
    cand0 = inc_mod3(rr_last_q);
    cand1 = inc_mod3(cand0);
    if (req_i[cand0])      winner = cand0;
    else if (req_i[cand1]) winner = cand1;
    else                   winner = rr_last_q;
    win_addr = addr_i[32'(winner)*ADDR_W +: ADDR_W];
    win_len  = len_i[32'(winner)*LEN_W +: LEN_W];
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_cnt_d   = addr_cnt_q;
    beats_left_d = beats_left_q;
    rr_last_d    = rr_last_q;
    first_d      = 1'b0;
    rvld_d       = (state_q == BURST) && (owner_q == 2'd1);
    case (state_q)
      IDLE: begin
        if (req_i != 3'b000) begin
          state_d      = BURST;
          owner_d      = winner;
          addr_cnt_d   = win_addr;
          beats_left_d = (win_len == '0) ? LEN_W'(1) : win_len;
          rr_last_d    = winner;
          first_d      = 1'b1;
        end
      end
      BURST: begin
        addr_cnt_d   = addr_cnt_q + ADDR_W'(1);
        beats_left_d = beats_left_q - LEN_W'(1);
        if (beats_left_q == LEN_W'(1) || abort_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      addr_cnt_q   <= '0;
      beats_left_q <= '0;
      rr_last_q    <= 2'd2;
      first_q      <= 1'b0;
      rvld_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_cnt_q   <= addr_cnt_d;
      beats_left_q <= beats_left_d;
      rr_last_q    <= rr_last_d;
      first_q      <= first_d;
      rvld_q       <= rvld_d;
    end
  end

  // Control outputs decode registered state only; data paths are combinational.
  always_comb begin
    in_burst     = (state_q == BURST);
    owner_oh     = 3'b001 << owner_q;
    busy_o       = in_burst;
    sram_cs_o    = in_burst;
    sram_we_o    = in_burst && (owner_q != 2'd1);
    sram_addr_o  = in_burst ? addr_cnt_q : '0;
    beat_o       = in_burst ? owner_oh : 3'b000;
    gnt_o        = (in_burst && first_q) ? owner_oh : 3'b000;
    cp_rvld_o    = rvld_q;
    cp_rdata_o   = sram_rdata_i;
    dbg_state_o  = state_q;
    sram_wdata_o = '0;
    if (in_burst && owner_q == 2'd0) sram_wdata_o = ld_wdata_i;
    if (in_burst && owner_q == 2'd2) sram_wdata_o = fm_wdata_i;
  end

endmodule
